// File: rtl/bitwise_pipe_unit.sv
// Multi-lane registered bitwise logic unit (AND/OR/XOR/XNOR) with per-lane parity
// and an accumulate mode that folds a burst of beats into a single result.
module bitwise_pipe_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned OP_W       = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]             op_i,
  input  logic                        acc_i,
  input  logic                        last_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [LANES*DATA_WIDTH-1:0] c_o,
  output logic [LANES-1:0]            parity_o,
  output logic                        acc_busy_o
);

  localparam int unsigned BUS_W = LANES * DATA_WIDTH;

  localparam logic [OP_W-1:0] OP_AND = OP_W'(0);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(2);

  logic [BUS_W-1:0] r_c;
  logic [LANES-1:0] r_par;
  logic             r_valid;
  logic             r_busy;
  logic [BUS_W-1:0] r_acc;
  logic [OP_W-1:0]  r_lop;

  logic             w_accept;
  logic             w_produce;
  logic             w_in_burst;
  logic [OP_W-1:0]  w_op;
  logic [BUS_W-1:0] w_r;
  logic [BUS_W-1:0] w_acc_next;
  logic [BUS_W-1:0] w_res;
  logic [LANES-1:0] w_par;

  // Every op is purely bitwise, so lanes never interact and the whole bus is processed at once.
  function automatic logic [BUS_W-1:0] bit_op(input logic [OP_W-1:0]  op,
                                              input logic [BUS_W-1:0] x,
                                              input logic [BUS_W-1:0] y);
    case (op)
      OP_AND:  bit_op = x & y;
      OP_OR:   bit_op = x | y;
      OP_XOR:  bit_op = x ^ y;
      default: bit_op = ~(x ^ y);
    endcase
  endfunction

  assign in_ready_o  = !r_valid || out_ready_i;
  assign out_valid_o = r_valid;
  assign c_o         = r_c;
  assign parity_o    = r_par;
  assign acc_busy_o  = r_busy;

  // Beat datapath: subsequent burst beats use the op latched on the first beat.
  always_comb begin
    w_accept   = in_valid_i && in_ready_o;
    w_in_burst = acc_i && r_busy;
    w_produce  = w_accept && (!acc_i || last_i);
    w_op       = w_in_burst ? r_lop : op_i;
    w_r        = bit_op(w_op, a_i, b_i);
    w_acc_next = bit_op(r_lop, r_acc, w_r);
    w_res      = w_in_burst ? w_acc_next : w_r;
    w_par      = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_par[k] = ^w_res[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_c     <= '0;
      r_par   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_acc   <= '0;
      r_lop   <= '0;
    end else begin
      if (w_produce) begin
        r_c     <= w_res;
        r_par   <= w_par;
        r_valid <= 1'b1;
      end else if (out_ready_i) begin
        r_valid <= 1'b0;
      end
      // Elementwise beats leave burst state alone, even mid-burst.
      if (w_accept && acc_i) begin
        if (!r_busy) begin
          r_lop  <= op_i;
          r_acc  <= w_r;
          r_busy <= !last_i;
        end else if (last_i) begin
          r_acc  <= '0;
          r_busy <= 1'b0;
        end else begin
          r_acc  <= w_acc_next;
        end
      end
    end
  end

endmodule
